// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side signals around the port arbiter.
// master: the arbiter itself; slave: the requesters and the memory it serves.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  lsu_req;
    logic                  lsu_we;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wstrb;
    logic                  lsu_gnt;
    logic                  lsu_rvalid;
    logic [DATA_W-1:0]     lsu_rdata;

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  bus_err;
    logic [ADDR_W-1:0]     err_addr;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata,
        output bus_err, err_addr
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata,
        input  bus_err, err_addr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and LSU traffic onto one single-port memory, one transaction in flight,
// LSU-first with a starvation guard for fetch and a response timeout that flags bus_err.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic          owner_lsu;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] timer;

    logic fetch_wins;
    logic grant_if;
    logic grant_lsu;
    logic resp;
    logic abort_txn;
    logic done;

    // Grants and responses are gated by reset so a reset cycle never hands anything out.
    always_comb begin
        fetch_wins = bus.if_req && (!bus.lsu_req || starve_cnt == SW'(STARVE_LIMIT));
        grant_if   = !reset && state == IDLE && fetch_wins;
        grant_lsu  = !reset && state == IDLE && bus.lsu_req && !fetch_wins;
        resp       = !reset && state == WAIT && bus.mem_rvalid;
        abort_txn  = !reset && state == WAIT && !bus.mem_rvalid && timer == TW'(TIMEOUT - 1);
        done       = resp || abort_txn;
    end

    assign bus.if_gnt     = grant_if;
    assign bus.lsu_gnt    = grant_lsu;
    assign bus.if_rvalid  = done && !owner_lsu;
    assign bus.lsu_rvalid = done && owner_lsu;
    assign bus.if_rdata   = (resp && !owner_lsu) ? bus.mem_rdata : '0;
    assign bus.lsu_rdata  = (resp && owner_lsu) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner_lsu     <= 1'b0;
            starve_cnt    <= '0;
            timer         <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.bus_err   <= 1'b0;
            bus.err_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_lsu) begin
                        state         <= ISSUE;
                        bus.mem_valid <= 1'b1;
                        owner_lsu     <= grant_lsu;
                        // A contested LSU win cannot reach the limit-plus-one, so no overflow here.
                        starve_cnt    <= (grant_lsu && bus.if_req) ? starve_cnt + 1'b1 : '0;
                        if (grant_if) begin
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_wstrb <= '0;
                        end else begin
                            bus.mem_we    <= bus.lsu_we;
                            bus.mem_addr  <= bus.lsu_addr;
                            bus.mem_wdata <= bus.lsu_wdata;
                            bus.mem_wstrb <= bus.lsu_wstrb;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        state         <= WAIT;
                        timer         <= '0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state <= IDLE;
                    end else if (abort_txn) begin
                        state       <= IDLE;
                        bus.bus_err <= 1'b1;
                        if (!bus.bus_err) begin
                            bus.err_addr <= bus.mem_addr;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench: requester and memory agents drive the arbiter while a transaction-level
// reference model predicts grants, memory requests, routed responses and the error flag.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        bit          isLsu;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    // Reference model: one transaction record plus the arbitration and error history.
    bit          mBusy;
    bit          mAccepted;
    int          mWait;
    int          mStreak;
    txn_t        mTxn;
    bit          mErr;
    logic [31:0] mErrAddr;
    logic [31:0] refArr [16];

    // Agents: requester hand-shaking and a small word memory answering the arbiter.
    bit          ifGranted;
    bit          lsuGranted;
    bit          outstanding;
    bit          noResp;
    bit          strayNext;
    int          waitLeft;
    logic [31:0] respData;
    logic [31:0] memArr [16];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = $urandom;
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic applyStimulus(input int reqRate, input bit doReset);
        int r;
        reset = doReset;
        if (!bus.if_req || ifGranted) begin
            bus.if_req  = ($urandom_range(0, 99) < reqRate);
            bus.if_addr = randAddr();
        end
        if (!bus.lsu_req || lsuGranted) begin
            bus.lsu_req   = ($urandom_range(0, 99) < reqRate);
            bus.lsu_we    = $urandom_range(0, 1);
            bus.lsu_addr  = randAddr();
            bus.lsu_wdata = $urandom;
            bus.lsu_wstrb = 4'($urandom);
        end
        r = $urandom_range(0, 99);
        bus.mem_ready  = (r < 60);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        if (!outstanding) begin
            if (strayNext || $urandom_range(0, 39) == 0) bus.mem_rvalid = 1'b1;
        end else if (!noResp) begin
            if (waitLeft == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = respData;
            end else begin
                waitLeft--;
            end
        end
        strayNext = 1'b0;
    endtask

    task automatic stepModel();
        bit          rst;
        bit          ifReq;
        bit          lsuReq;
        bit          eIfGnt;
        bit          eLsuGnt;
        bit          eMemValid;
        bit          eIfRv;
        bit          eLsuRv;
        bit          respond;
        bit          abort;
        logic [31:0] eRdata;
        int          idx;
        rst = reset;
        ifReq = bus.if_req;
        lsuReq = bus.lsu_req;
        eIfGnt = 0; eLsuGnt = 0; eMemValid = 0; eIfRv = 0; eLsuRv = 0;
        respond = 0; abort = 0; eRdata = '0;

        if (!mBusy) begin
            if (!rst && (ifReq || lsuReq)) begin
                eIfGnt  = ifReq && (!lsuReq || mStreak == STARVE_LIMIT);
                eLsuGnt = !eIfGnt;
            end
        end else if (!mAccepted) begin
            eMemValid = 1;
        end else begin
            respond = bus.mem_rvalid;
            abort   = !respond && mWait == TIMEOUT - 1;
            if (!rst && (respond || abort)) begin
                if (mTxn.isLsu) eLsuRv = 1; else eIfRv = 1;
                eRdata = respond ? mTxn.rdata : 32'h0;
            end
        end

        checkOutput("if_gnt", bus.if_gnt, eIfGnt);
        checkOutput("lsu_gnt", bus.lsu_gnt, eLsuGnt);
        checkOutput("mem_valid", bus.mem_valid, eMemValid);
        checkOutput("if_rvalid", bus.if_rvalid, eIfRv);
        checkOutput("lsu_rvalid", bus.lsu_rvalid, eLsuRv);
        checkOutput("bus_err", bus.bus_err, mErr);
        checkOutput("err_addr", bus.err_addr, mErrAddr);
        if (eMemValid) begin
            checkOutput("mem_we", bus.mem_we, mTxn.we);
            checkOutput("mem_addr", bus.mem_addr, mTxn.addr);
            checkOutput("mem_wdata", bus.mem_wdata, mTxn.wdata);
            checkOutput("mem_wstrb", bus.mem_wstrb, mTxn.wstrb);
        end
        if (eIfRv) checkOutput("if_rdata", bus.if_rdata, eRdata);
        if (eLsuRv && (!mTxn.we || abort)) checkOutput("lsu_rdata", bus.lsu_rdata, eRdata);

        if (rst) begin
            if (mBusy && !mAccepted && bus.mem_ready && mTxn.we) begin
                idx = int'(mTxn.addr[5:2]);
                refArr[idx] = mergeStore(refArr[idx], mTxn.wdata, mTxn.wstrb);
            end
            mBusy = 0; mAccepted = 0; mWait = 0; mStreak = 0; mErr = 0; mErrAddr = '0;
        end else if (!mBusy) begin
            if (eIfGnt || eLsuGnt) begin
                mTxn.isLsu = eLsuGnt;
                mTxn.we    = eLsuGnt ? bus.lsu_we : 1'b0;
                mTxn.addr  = eLsuGnt ? bus.lsu_addr : bus.if_addr;
                mTxn.wdata = eLsuGnt ? bus.lsu_wdata : 32'h0;
                mTxn.wstrb = eLsuGnt ? bus.lsu_wstrb : 4'h0;
                mStreak    = (eLsuGnt && ifReq) ? mStreak + 1 : 0;
                mBusy      = 1;
                mAccepted  = 0;
            end
        end else if (!mAccepted) begin
            if (bus.mem_ready) begin
                mAccepted  = 1;
                mWait      = 0;
                idx        = int'(mTxn.addr[5:2]);
                mTxn.rdata = refArr[idx];
                if (mTxn.we) refArr[idx] = mergeStore(refArr[idx], mTxn.wdata, mTxn.wstrb);
            end
        end else if (respond) begin
            mBusy = 0;
        end else if (abort) begin
            mBusy = 0;
            if (!mErr) mErrAddr = mTxn.addr;
            mErr = 1;
        end else begin
            mWait++;
        end
    endtask

    task automatic updateAgents();
        int idx;
        int r;
        ifGranted  = bus.if_gnt;
        lsuGranted = bus.lsu_gnt;
        if (bus.mem_valid && bus.mem_ready) begin
            idx      = int'(bus.mem_addr[5:2]);
            respData = memArr[idx];
            if (bus.mem_we) memArr[idx] = mergeStore(memArr[idx], bus.mem_wdata, bus.mem_wstrb);
            outstanding = 1;
            noResp      = ($urandom_range(0, 14) == 0);
            r           = $urandom_range(0, 19);
            waitLeft    = (r < 17) ? r % 5 : ((r == 17) ? TIMEOUT - 2 : TIMEOUT - 1);
        end
        if (bus.if_rvalid || bus.lsu_rvalid) outstanding = 0;
        if (reset) begin
            outstanding = 0;
            strayNext   = 1;
        end
    endtask

    initial begin
        bit doReset;
        int reqRate;
        bus.if_req = 0; bus.if_addr = '0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wstrb = '0;
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            refArr[i] = $urandom;
            memArr[i] = refArr[i];
        end
        mBusy = 0; mAccepted = 0; mWait = 0; mStreak = 0; mErr = 0; mErrAddr = '0;
        mTxn = '{default: '0};
        ifGranted = 0; lsuGranted = 0; outstanding = 0; noResp = 0; strayNext = 0;
        waitLeft = 0; respData = '0;

        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            doReset = (cyc < 2) || (outstanding && $urandom_range(0, 199) == 0);
            reqRate = (cyc < 2800) ? 50 : 100;
            applyStimulus(reqRate, doReset);
            @(negedge clk);
            stepModel();
            updateAgents();
        end
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
